cache_arbiter: RTL and testbench

Shares the single physical-memory port between the instruction-cache and data-cache miss paths of the LC-3b cache system. Each cache issues whole-line (128-bit) reads; the data cache also issues line write-backs. The block sits between the two caches and physical memory inside `cache_system`. It serializes transactions, latches the winning request for the full transaction, routes the response back to its owner, and breaks conflicts round-robin.

---
 rtl/cache_arbiter_pkg.sv | 22 ++
 rtl/cache_arbiter_if.sv | 43 ++++
 rtl/cache_arbiter_control.sv | 66 ++++++
 rtl/cache_arbiter.sv | 75 +++++++
 tb/tb_cache_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the LC-3b cache-to-memory arbiter: line/word widths,
// arbiter FSM states and client identifiers.
package cache_arbiter_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 16;

  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } arb_client;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two cache miss paths, the arbiter and physical memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface cache_arbiter_if;
  import cache_arbiter_pkg::*;

  logic     icache_pmem_read;
  lc3b_word icache_pmem_address;
  lc3b_line icache_pmem_rdata;
  logic     icache_pmem_resp;

  logic     dcache_pmem_read;
  logic     dcache_pmem_write;
  lc3b_word dcache_pmem_address;
  lc3b_line dcache_pmem_wdata;
  lc3b_line dcache_pmem_rdata;
  logic     dcache_pmem_resp;

  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM with round-robin conflict resolution; emits one-cycle grant
// pulses (latch enables) and a done pulse when memory completes.
//   state   | meaning
//   IDLE    | no transaction in progress
//   SERVE_I | I-cache transaction in progress
//   SERVE_D | D-cache transaction in progress
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          pmem_resp,
  output lc3b_arb_state state,
  output logic          grant_i,
  output logic          grant_d,
  output logic          done
);

  lc3b_arb_state state_q, state_d;
  arb_client     last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_I;
    end else begin
      state_q <= state_d;
      if (grant_i) last_grant_q <= CLIENT_I;
      else if (grant_d) last_grant_q <= CLIENT_D;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a conflict the client that did not win last time goes first.
        if (i_req && d_req) begin
          if (last_grant_q == CLIENT_I) grant_d = 1'b1;
          else                          grant_i = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_d = SERVE_I;
        if (grant_d) state_d = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths:
// latches the winner's request at grant and routes the response to its owner.
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);

  lc3b_arb_state state;
  logic          grant_i, grant_d, done;
  logic          i_req, d_req, d_is_write;

  lc3b_word addr_q;
  lc3b_line wdata_q;
  logic     read_q, write_q;

  assign i_req      = bus.icache_pmem_read;
  assign d_req      = bus.dcache_pmem_read | bus.dcache_pmem_write;
  // Read+write together is illegal; the write-back wins.
  assign d_is_write = bus.dcache_pmem_write;

  cache_arbiter_control u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .d_req     (d_req),
    .pmem_resp (bus.pmem_resp),
    .state     (state),
    .grant_i   (grant_i),
    .grant_d   (grant_d),
    .done      (done)
  );

  // Strobes are set on the grant edge and cleared on the completion edge, so
  // they are pure flops with no path from client inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (grant_i) begin
      addr_q  <= bus.icache_pmem_address;
      read_q  <= 1'b1;
      write_q <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= bus.dcache_pmem_address;
      wdata_q <= bus.dcache_pmem_wdata;
      read_q  <= ~d_is_write;
      write_q <= d_is_write;
    end else if (done) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && grant_d) begin
      assert (!(bus.dcache_pmem_read && bus.dcache_pmem_write));
    end
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;
  assign bus.icache_pmem_resp  = done && (state == SERVE_I);
  assign bus.dcache_pmem_resp  = done && (state == SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-client transfers, round-robin
// conflicts, input changes mid-transaction, stray responses and async reset.
module tb_cache_arbiter;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_WB = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LINE_D1 = 128'h11112222333344445555666677778888;
  localparam logic [127:0] LINE_I1 = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [127:0] data);
    bus.pmem_rdata = data;
    bus.pmem_resp  = 1'b1;
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.pmem_rdata          = '0;
    bus.pmem_resp           = 1'b0;
    tick();
    tick();

    chk("rst_pmem_read",  128'(bus.pmem_read), 128'd0);
    chk("rst_pmem_write", 128'(bus.pmem_write), 128'd0);
    chk("rst_address",    128'(bus.pmem_address), 128'd0);
    chk("rst_wdata",      bus.pmem_wdata, 128'd0);
    chk("rst_iresp",      128'(bus.icache_pmem_resp), 128'd0);
    chk("rst_dresp",      128'(bus.dcache_pmem_resp), 128'd0);
    rst = 1'b0;

    // I-cache only, memory answers in the fifth strobe cycle
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1230;
    tick();
    chk("i_pmem_read",  128'(bus.pmem_read), 128'd1);
    chk("i_pmem_write", 128'(bus.pmem_write), 128'd0);
    chk("i_address",    128'(bus.pmem_address), 128'h1230);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("i_read_hold", 128'(bus.pmem_read), 128'd1);
      chk("i_no_resp",   128'(bus.icache_pmem_resp), 128'd0);
    end
    respond(LINE_A5);
    chk("i_resp",       128'(bus.icache_pmem_resp), 128'd1);
    chk("i_rdata",      bus.icache_pmem_rdata, LINE_A5);
    chk("i_dresp_zero", 128'(bus.dcache_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    chk("i_read_drop", 128'(bus.pmem_read), 128'd0);
    chk("i_resp_drop", 128'(bus.icache_pmem_resp), 128'd0);

    // Back to reset so the first conflict sees last_grant = I-cache
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Conflict 1: D-cache first, one idle cycle, then I-cache
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1000;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h2000;
    tick();
    chk("c1_first_addr", 128'(bus.pmem_address), 128'h2000);
    chk("c1_first_read", 128'(bus.pmem_read), 128'd1);
    respond(LINE_D1);
    chk("c1_dresp",       128'(bus.dcache_pmem_resp), 128'd1);
    chk("c1_drdata",      bus.dcache_pmem_rdata, LINE_D1);
    chk("c1_iresp_zero",  128'(bus.icache_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    #1;
    chk("c1_idle_gap", 128'(bus.pmem_read), 128'd0);
    tick();
    chk("c1_second_addr", 128'(bus.pmem_address), 128'h1000);
    chk("c1_second_read", 128'(bus.pmem_read), 128'd1);
    respond(LINE_I1);
    chk("c1_iresp",      128'(bus.icache_pmem_resp), 128'd1);
    chk("c1_irdata",     bus.icache_pmem_rdata, LINE_I1);
    chk("c1_dresp_zero", 128'(bus.dcache_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    chk("c1_end_read", 128'(bus.pmem_read), 128'd0);

    // D-cache write-back; client inputs wander mid-transaction
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h4560;
    bus.dcache_pmem_wdata   = LINE_WB;
    tick();
    chk("wb_write",   128'(bus.pmem_write), 128'd1);
    chk("wb_read",    128'(bus.pmem_read), 128'd0);
    chk("wb_address", 128'(bus.pmem_address), 128'h4560);
    chk("wb_wdata",   bus.pmem_wdata, LINE_WB);
    bus.dcache_pmem_address = 16'h7770;
    bus.dcache_pmem_wdata   = '1;
    bus.icache_pmem_address = 16'hBEE0;
    tick();
    tick();
    chk("wb_addr_hold",  128'(bus.pmem_address), 128'h4560);
    chk("wb_wdata_hold", bus.pmem_wdata, LINE_WB);
    respond(LINE_A5);
    chk("wb_dresp",      128'(bus.dcache_pmem_resp), 128'd1);
    chk("wb_iresp_zero", 128'(bus.icache_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    #1;
    chk("wb_write_drop", 128'(bus.pmem_write), 128'd0);

    // Conflict 2 after a D grant: I-cache first, then D-cache
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h3000;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h4000;
    tick();
    chk("c2_first_addr", 128'(bus.pmem_address), 128'h3000);
    respond(LINE_I1);
    chk("c2_iresp",      128'(bus.icache_pmem_resp), 128'd1);
    chk("c2_dresp_zero", 128'(bus.dcache_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    chk("c2_idle_gap", 128'(bus.pmem_read), 128'd0);
    tick();
    chk("c2_second_addr", 128'(bus.pmem_address), 128'h4000);
    chk("c2_second_read", 128'(bus.pmem_read), 128'd1);
    respond(LINE_D1);
    chk("c2_dresp", 128'(bus.dcache_pmem_resp), 128'd1);
    tick();
    bus.pmem_resp = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    #1;

    // Stray response while idle
    respond(LINE_A5);
    chk("stray_iresp", 128'(bus.icache_pmem_resp), 128'd0);
    chk("stray_dresp", 128'(bus.dcache_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    chk("stray_read",  128'(bus.pmem_read), 128'd0);
    chk("stray_write", 128'(bus.pmem_write), 128'd0);

    // Async reset in the middle of a D-cache transaction
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h5550;
    tick();
    chk("rd_pre_read", 128'(bus.pmem_read), 128'd1);
    rst = 1'b1;
    bus.pmem_resp = 1'b1;
    #1;
    chk("rd_rst_read",  128'(bus.pmem_read), 128'd0);
    chk("rd_rst_write", 128'(bus.pmem_write), 128'd0);
    chk("rd_rst_dresp", 128'(bus.dcache_pmem_resp), 128'd0);
    chk("rd_rst_addr",  128'(bus.pmem_address), 128'd0);
    bus.pmem_resp = 1'b0;
    bus.dcache_pmem_read    = 1'b0;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h6660;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_read", 128'(bus.pmem_read), 128'd1);
    chk("post_rst_addr", 128'(bus.pmem_address), 128'h6660);
    respond(LINE_I1);
    chk("post_rst_iresp", 128'(bus.icache_pmem_resp), 128'd1);
    tick();
    bus.pmem_resp = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    chk("post_rst_drop", 128'(bus.pmem_read), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
